// File: rtl/mips_timer.sv
// mips_timer: memory-mapped countdown timer for the system bridge.
// Register window (word offset Addr[1:0] of the 30-bit word address):
//   0 CTRL {IM, Mode[1:0], En}, 1 PRESET, 2 COUNT (read-only), 3 reserved.
// IRQ feeds CP0 HWInt[0].
// Optional build macro TIMER_PRESCALE_EN adds a PRESCALE-cycle divider
// in front of the countdown.
module mips_timer #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        tick;

    logic        en;
    logic [1:0]  mode;
    logic        im;

    assign en   = ctrl[0];
    assign mode = ctrl[2:1];
    assign im   = ctrl[3];

    // A zero prescale would never let the countdown advance.
    if (PRESCALE == 0) begin : g_prescale_invalid
        logic prescale_must_be_nonzero;
        assign prescale_must_be_nonzero = 1'b0;
    end

`ifdef TIMER_PRESCALE_EN
    logic [31:0] prescaler;

    assign tick = (prescaler == PRESCALE - 1);

    // Divider runs only while counting; any other state restarts it.
    always_ff @(posedge clk) begin
        if (reset)
            prescaler <= '0;
        else if (state == CNT)
            prescaler <= tick ? '0 : prescaler + 32'd1;
        else
            prescaler <= '0;
    end
`else
    assign tick = 1'b1;
`endif

    // Countdown FSM plus CPU register writes; a CPU write to CTRL is
    // applied last so it overrides the FSM's own En-clear on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en)
                        state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= en ? CNT : IDLE;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (count > 32'd1) begin
                            count <= count - 32'd1;
                        end else begin
                            count    <= '0;
                            irq_flag <= 1'b1;
                            state    <= INT;
                        end
                    end
                end
                INT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (mode == 2'd1) begin
                        irq_flag <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (WE) begin
                if (Addr[1:0] == A_CTRL) begin
                    ctrl     <= Din[3:0];
                    irq_flag <= 1'b0;
                end else if (Addr[1:0] == A_PRESET) begin
                    preset <= Din;
                end
            end
        end
    end

    // Read mux: combinational from the registered state.
    always_comb begin
        Dout = '0;
        case (Addr[1:0])
            A_CTRL:   Dout = {28'b0, ctrl};
            A_PRESET: Dout = preset;
            A_COUNT:  Dout = count;
            default:  Dout = '0;
        endcase
    end

    assign IRQ = irq_flag & im;

endmodule

// File: tb/tb_mips_timer.sv
// tb_mips_timer: directed/randomized bench for mips_timer (default build).
// Expected values come from the timing rules: after a CTRL write with En=1
// at edge t0 and PRESET=N, COUNT reads N-(k-2) after edge t0+k, the flag
// sets at t0+N+2 and auto-reload repeats every N+2 edges.
module tb_mips_timer;

    logic        clk;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    mips_timer #(.PRESCALE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'b0, a};
        Din  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = {28'b0, a};
        #1;
        d = Dout;
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'b0, IRQ}, {31'b0, exp});
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    // One-shot with IM=1: COUNT walks down, IRQ rises at t0+N+2 and holds.
    task automatic run_oneshot(input int unsigned n);
        int unsigned neff;
        logic [31:0] exp_cnt;
        neff = (n == 0) ? 1 : n;
        wr(2'd1, n);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= int'(neff) + 2; k++) begin
            step();
            chk_irq("oneshot_irq", k == int'(neff) + 2);
            if (k >= 2) begin
                if (k <= int'(neff) + 1)
                    exp_cnt = (n == 0) ? 32'd0 : n - (k - 2);
                else
                    exp_cnt = 32'd0;
                chk_reg("oneshot_count", 2'd2, exp_cnt);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk_irq("oneshot_irq_hold", 1'b1);
        end
        chk_reg("oneshot_ctrl_after", 2'd0, 32'h8);
        wr(2'd0, 32'h0);
        chk_irq("oneshot_irq_clear", 1'b0);
    endtask

    // Auto-reload: one-cycle pulses every N+2 edges, first at t0+N+2.
    task automatic run_auto(input int unsigned n);
        int p;
        p = int'(n) + 2;
        wr(2'd1, n);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 4 * p; k++) begin
            step();
            chk_irq("auto_irq", (k >= p) && (k % p == 0));
            if (k == 2)
                chk_reg("auto_first_load", 2'd2, n);
        end
        wr(2'd0, 32'h0);
        for (int k = 0; k < p + 2; k++) begin
            step();
            chk_irq("auto_stopped_irq", 1'b0);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] pv;
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        step();
        step();

        // Reset values
        chk_reg("reset_ctrl", 2'd0, 32'h0);
        chk_reg("reset_preset", 2'd1, 32'h0);
        chk_reg("reset_count", 2'd2, 32'h0);
        chk_irq("reset_irq", 1'b0);
        reset = 1'b0;
        step();
        chk_irq("post_reset_irq", 1'b0);

        // PRESET readback with random data; reserved/COUNT writes ignored
        for (int i = 0; i < 4; i++) begin
            pv = $urandom;
            wr(2'd1, pv);
            chk_reg("preset_rw", 2'd1, pv);
        end
        wr(2'd2, $urandom);
        chk_reg("count_readonly", 2'd2, 32'h0);
        wr(2'd3, $urandom);
        chk_reg("reserved_read", 2'd3, 32'h0);
        chk_reg("preset_kept", 2'd1, pv);
        wr(2'd0, 32'hFFFF_FFF0);
        chk_reg("ctrl_upper_zero", 2'd0, 32'h0);

        // One-shot
        run_oneshot(5);
        run_oneshot($urandom_range(1, 12));
        run_oneshot(0);

        // Auto-reload
        run_auto(3);
        run_auto($urandom_range(1, 6));

        // Masking: flag sets with IM=0, later write clears it
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_irq("mask_irq", 1'b0);
        end
        chk_reg("mask_ctrl", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk_irq("mask_clear_irq", 1'b0);
        step();
        chk_irq("mask_clear_irq2", 1'b0);
        chk_reg("mask_ctrl2", 2'd0, 32'h8);

        // Mid-count abort with PRESET rewrite mid-count
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 10; k++) step();
        chk_reg("abort_count_k10", 2'd2, 32'd92);
        wr(2'd1, 32'd7);
        chk_reg("abort_count_k11", 2'd2, 32'd91);
        chk_reg("abort_preset", 2'd1, 32'd7);
        for (int k = 12; k <= 52; k++) step();
        chk_reg("abort_count_k52", 2'd2, 32'd50);
        wr(2'd0, 32'h8);
        chk_reg("abort_count_k53", 2'd2, 32'd49);
        for (int k = 0; k < 5; k++) begin
            step();
            chk_reg("abort_count_hold", 2'd2, 32'd49);
            chk_irq("abort_irq", 1'b0);
        end
        chk_reg("abort_ctrl", 2'd0, 32'h8);

        // Collision: CPU CTRL write on the one-shot INT edge
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) step();
        chk_irq("coll_irq_set", 1'b1);
        wr(2'd0, 32'h9);
        chk_irq("coll_irq_cleared", 1'b0);
        chk_reg("coll_ctrl", 2'd0, 32'h9);
        step();
        step();
        chk_reg("coll_reload", 2'd2, 32'd4);
        for (int k = 10; k <= 13; k++) begin
            step();
            chk_irq("coll_second_irq", k == 13);
        end
        wr(2'd0, 32'h0);

        // Reset mid-count
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 12; k++) step();
        chk_reg("rst_mid_count", 2'd2, 32'd10);
        reset = 1'b1;
        step();
        chk_reg("rst_ctrl", 2'd0, 32'h0);
        chk_reg("rst_preset", 2'd1, 32'h0);
        chk_reg("rst_count", 2'd2, 32'h0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            chk_irq("rst_after_irq", 1'b0);
        end
        chk_reg("rst_after_count", 2'd2, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
